// File: rtl/ser_link_ctrl.sv
// ser_link_ctrl: word serializer (TX) and deserializer (RX) sharing one clock.
// TX shifts a WIDTH-bit word out one bit per clk framed by ser_ena, then holds
// off tx_ready for GAP cycles. RX rebuilds words from the selected serial
// source (external pins, or ser_out/ser_ena when loopback=1).
// Build option: define PARITY_EN to append an even-parity bit to every frame
// and check it on receive (rx_perr); otherwise frames are WIDTH bits long.
//
// TX states:  TX_IDLE  | ready for a word
//             TX_SHIFT | driving frame bits on ser_out
//             TX_GAP   | forced idle after a frame
// RX states:  RX_IDLE  | waiting for the first bit of a frame
//             RX_SHIFT | collecting the remaining frame bits
module ser_link_ctrl #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             ser_out,
    output logic             ser_ena,
    input  logic             loopback,
    input  logic             ser_in,
    input  logic             ser_in_ena,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             rx_abort,
    output logic             rx_perr
);

`ifdef PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif
    localparam int            CW     = $clog2(FL + 1);
    localparam logic [CW-1:0] LAST   = CW'(FL - 1);
    localparam logic [3:0]    GAP_LD = 4'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_GAP} tx_state_t;
    typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;

    tx_state_t     tx_state_q, tx_state_d;
    logic [FL-1:0] tx_sh_q, tx_sh_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    gap_cnt_q, gap_cnt_d;
    logic          live_q;
    logic [FL-1:0] tx_frame;

    rx_state_t     rx_state_q, rx_state_d;
    logic [FL-2:0] rx_sh_q, rx_sh_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_abort_q, rx_abort_d;
    logic          lb_q;
    logic          rx_ena, rx_bit;
    logic [FL-1:0] rx_sh_nxt;
    logic [WIDTH-1:0] rx_word;
`ifdef PARITY_EN
    logic          rx_perr_q, rx_perr_d;
    logic          rx_par_bad;
`endif

    // Assemble the frame in transmit order; parity always goes out last.
    always_comb begin
`ifdef PARITY_EN
        if (MSB_FIRST != 0) tx_frame = {tx_data, ^tx_data};
        else                tx_frame = {^tx_data, tx_data};
`else
        tx_frame = tx_data;
`endif
    end

    // TX state register; live_q keeps tx_ready low for the first edge after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_sh_q    <= '0;
            tx_cnt_q   <= '0;
            gap_cnt_q  <= '0;
            live_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_sh_q    <= tx_sh_d;
            tx_cnt_q   <= tx_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            live_q     <= 1'b1;
        end
    end

    // TX next state: bit counter and gap timer both count down to zero.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_sh_d    = tx_sh_q;
        tx_cnt_d   = tx_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (live_q && tx_valid) begin
                    tx_sh_d    = tx_frame;
                    tx_cnt_d   = LAST;
                    tx_state_d = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (tx_cnt_q == '0) begin
                    tx_sh_d = '0;
                    if (GAP == 0) begin
                        tx_state_d = TX_IDLE;
                    end else begin
                        gap_cnt_d  = GAP_LD;
                        tx_state_d = TX_GAP;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                    if (MSB_FIRST != 0) tx_sh_d = {tx_sh_q[FL-2:0], 1'b0};
                    else                tx_sh_d = {1'b0, tx_sh_q[FL-1:1]};
                end
            end
            TX_GAP: begin
                if (gap_cnt_q == '0) tx_state_d = TX_IDLE;
                else                 gap_cnt_d  = gap_cnt_q - 1'b1;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // TX outputs; ser_out is forced low outside a frame.
    always_comb begin
        tx_ready = (tx_state_q == TX_IDLE) && live_q;
        ser_ena  = (tx_state_q == TX_SHIFT);
        ser_out  = ser_ena && ((MSB_FIRST != 0) ? tx_sh_q[FL-1] : tx_sh_q[0]);
    end

    // RX source select and frame decode from the stored bits plus the current bit.
    always_comb begin
        rx_ena = loopback ? ser_ena : ser_in_ena;
        rx_bit = loopback ? ser_out : ser_in;
        if (MSB_FIRST != 0) rx_sh_nxt = {rx_sh_q, rx_bit};
        else                rx_sh_nxt = {rx_bit, rx_sh_q};
`ifdef PARITY_EN
        if (MSB_FIRST != 0) begin
            rx_word    = rx_sh_nxt[FL-1:1];
            rx_par_bad = ^rx_sh_nxt;
        end else begin
            rx_word    = rx_sh_nxt[WIDTH-1:0];
            rx_par_bad = ^rx_sh_nxt;
        end
`else
        rx_word = rx_sh_nxt;
`endif
    end

    // RX state register; reset drops any partial frame without an abort pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_sh_q    <= '0;
            rx_cnt_q   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_abort_q <= 1'b0;
            lb_q       <= 1'b0;
`ifdef PARITY_EN
            rx_perr_q  <= 1'b0;
`endif
        end else begin
            rx_state_q <= rx_state_d;
            rx_sh_q    <= rx_sh_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_abort_q <= rx_abort_d;
            lb_q       <= loopback;
`ifdef PARITY_EN
            rx_perr_q  <= rx_perr_d;
`endif
        end
    end

    // RX next state: a loopback change mid-frame is handled like ena dropping.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_sh_d    = rx_sh_q;
        rx_cnt_d   = rx_cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_abort_d = 1'b0;
`ifdef PARITY_EN
        rx_perr_d  = 1'b0;
`endif
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_ena) begin
                    rx_sh_d    = (MSB_FIRST != 0) ? rx_sh_nxt[FL-2:0] : rx_sh_nxt[FL-1:1];
                    rx_cnt_d   = CW'(1);
                    rx_state_d = RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                if (!rx_ena || (loopback != lb_q)) begin
                    rx_abort_d = 1'b1;
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                end else if (rx_cnt_q == LAST) begin
                    rx_data_d  = rx_word;
                    rx_valid_d = 1'b1;
`ifdef PARITY_EN
                    rx_perr_d  = rx_par_bad;
`endif
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_sh_d  = (MSB_FIRST != 0) ? rx_sh_nxt[FL-2:0] : rx_sh_nxt[FL-1:1];
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX outputs straight from their flops.
    always_comb begin
        rx_data  = rx_data_q;
        rx_valid = rx_valid_q;
        rx_abort = rx_abort_q;
`ifdef PARITY_EN
        rx_perr  = rx_perr_q;
`else
        rx_perr  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_ser_link_ctrl.sv
// Directed bench for ser_link_ctrl: a default instance (MSB first, GAP=1) and
// an LSB-first GAP=0 instance; received words are checked against a scoreboard.
module tb_ser_link_ctrl;
    localparam int W = 8;
`ifdef PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif
    localparam logic [31:0] FLMASK  = (32'd1 << FL) - 32'd1;
    localparam logic [31:0] WINMASK = (32'd1 << (FL + 4)) - 32'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, tx_valid, tx_ready, ser_out, ser_ena, loopback, ser_in, ser_in_ena;
    logic [W-1:0] tx_data, rx_data;
    logic         rx_valid, rx_abort, rx_perr;

    logic         b_tx_valid, b_tx_ready, b_ser_out, b_ser_ena, b_loopback, b_ser_in, b_ser_in_ena;
    logic [W-1:0] b_tx_data, b_rx_data;
    logic         b_rx_valid, b_rx_abort, b_rx_perr;

    ser_link_ctrl #(.WIDTH(W), .MSB_FIRST(1), .GAP(1)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ser_out(ser_out), .ser_ena(ser_ena), .loopback(loopback), .ser_in(ser_in),
        .ser_in_ena(ser_in_ena), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_abort(rx_abort), .rx_perr(rx_perr));

    ser_link_ctrl #(.WIDTH(W), .MSB_FIRST(0), .GAP(0)) dut_lsb (
        .clk(clk), .rst(rst), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
        .ser_out(b_ser_out), .ser_ena(b_ser_ena), .loopback(b_loopback), .ser_in(b_ser_in),
        .ser_in_ena(b_ser_in_ena), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
        .rx_abort(b_rx_abort), .rx_perr(b_rx_perr));

    int vec = 0;
    int err = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_b[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vec++;
        assert (obs === expv) else begin
            err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Index i holds the i-th bit on the line; bit 8 is the (optionally flipped) parity.
    function automatic logic [31:0] fbits(input logic [7:0] d, input bit msb, input bit flip);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i] = msb ? d[7-i] : d[i];
        r[8] = (^d) ^ flip;
        return r & FLMASK;
    endfunction

    task automatic sb_pop(input string tag, input bit use_b, input logic [8:0] got);
        logic [8:0] e;
        int n;
        n = use_b ? exp_b.size() : exp_q.size();
        chk({tag, "_pending"}, 32'(n > 0), 32'd1);
        if (n > 0) begin
            e = use_b ? exp_b.pop_front() : exp_q.pop_front();
            chk(tag, 32'(got), 32'(e));
        end
    endtask

    task automatic lb_send(input string tag, input logic [7:0] d);
        logic [31:0] ena_pat, out_pat;
        int n, lat, nval;
        n = 0;
        while (!tx_ready && n < 50) begin step(); n++; end
        chk({tag, "_ready"}, 32'(tx_ready), 32'd1);
        tx_data = d; tx_valid = 1'b1;
        exp_q.push_back({1'b0, d});
        step();
        tx_valid = 1'b0;
        ena_pat = '0; out_pat = '0; lat = 0; nval = 0;
        for (int c = 1; c <= FL + 4; c++) begin
            ena_pat[c-1] = ser_ena;
            out_pat[c-1] = ser_out;
            if (rx_valid) begin
                nval++; lat = c;
                sb_pop({tag, "_rx"}, 1'b0, {rx_perr, rx_data});
            end
            step();
        end
        chk({tag, "_ena"}, ena_pat, FLMASK);
        chk({tag, "_bits"}, out_pat, fbits(d, 1'b1, 1'b0));
        chk({tag, "_nvalid"}, 32'(nval), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(FL + 1));
    endtask

    task automatic ext_frame(input string tag, input logic [31:0] fb, input int n,
                             output int nval, output int nab);
        nval = 0; nab = 0;
        for (int i = 0; i < n; i++) begin
            ser_in_ena = 1'b1; ser_in = fb[i];
            step();
            if (rx_valid) begin nval++; sb_pop({tag, "_rx"}, 1'b0, {rx_perr, rx_data}); end
            if (rx_abort) nab++;
        end
        ser_in_ena = 1'b0; ser_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rx_valid) begin nval++; sb_pop({tag, "_rx"}, 1'b0, {rx_perr, rx_data}); end
            if (rx_abort) nab++;
        end
    endtask

    initial begin
        logic [31:0] ena_pat, out_pat, rdy_pat;
        int n, lat, nval, nab, sent, phase, zc, gc, nrx, a0, a1;

        rst = 1'b1; tx_valid = 1'b0; tx_data = '0; loopback = 1'b1;
        ser_in = 1'b0; ser_in_ena = 1'b0;
        b_tx_valid = 1'b0; b_tx_data = '0; b_loopback = 1'b1; b_ser_in = 1'b0; b_ser_in_ena = 1'b0;
        step(); step();
        chk("reset_ctl", 32'({tx_ready, ser_out, ser_ena, rx_valid, rx_abort, rx_perr}), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        rst = 1'b0;
        step();
        chk("ready_after_release", 32'(tx_ready), 32'd1);
        chk("lsb_ready_after_release", 32'(b_tx_ready), 32'd1);

        // Loopback, MSB first
        lb_send("lb_a5", 8'hA5);
        lb_send("lb_3c", 8'h3C);

        // LSB first, GAP=0 instance
        b_tx_data = 8'h01; b_tx_valid = 1'b1;
        exp_b.push_back({1'b0, 8'h01});
        step();
        b_tx_valid = 1'b0;
        ena_pat = '0; out_pat = '0; rdy_pat = '0; lat = 0; nval = 0;
        for (int c = 1; c <= FL + 4; c++) begin
            ena_pat[c-1] = b_ser_ena;
            out_pat[c-1] = b_ser_out;
            rdy_pat[c-1] = b_tx_ready;
            if (b_rx_valid) begin
                nval++; lat = c;
                sb_pop("lsb_rx", 1'b1, {b_rx_perr, b_rx_data});
            end
            step();
        end
        chk("lsb_ena", ena_pat, FLMASK);
        chk("lsb_bits", out_pat, fbits(8'h01, 1'b0, 1'b0));
        chk("lsb_ready_gap0", rdy_pat, WINMASK & ~FLMASK);
        chk("lsb_nvalid", 32'(nval), 32'd1);
        chk("lsb_latency", 32'(lat), 32'(FL + 1));

        // tx_valid held high across two words
        n = 0;
        while (!tx_ready && n < 50) begin step(); n++; end
        tx_data = 8'h11; tx_valid = 1'b1;
        sent = 0; phase = 0; zc = 0; gc = 0; nrx = 0; a0 = 0; a1 = 0;
        for (int c = 0; c < 3 * FL + 10; c++) begin
            if (tx_ready && tx_valid) begin
                exp_q.push_back({1'b0, tx_data});
                sent++;
                if (sent == 1) a0 = c; else a1 = c;
            end
            step();
            if (sent == 1) tx_data = 8'h22;
            else if (sent >= 2) tx_valid = 1'b0;
            if (phase == 0) begin
                if (ser_ena) phase = 1;
            end else if (phase == 1) begin
                if (!ser_ena) begin
                    phase = 2; zc = 1;
                    if (!tx_ready) gc = 1;
                end
            end else if (phase == 2) begin
                if (ser_ena) phase = 3;
                else begin
                    zc++;
                    if (!tx_ready) gc++;
                end
            end
            if (rx_valid) begin nrx++; sb_pop("b2b_rx", 1'b0, {rx_perr, rx_data}); end
        end
        chk("b2b_sent", 32'(sent), 32'd2);
        chk("b2b_received", 32'(nrx), 32'd2);
        chk("b2b_forced_gap", 32'(gc), 32'd1);
        chk("b2b_ena_low_cycles", 32'(zc), 32'd2);
        chk("b2b_accept_spacing", 32'(a1 - a0), 32'(FL + 2));

        // External RX: full frame, short frame, back-to-back frames
        loopback = 1'b0;
        step();
        exp_q.push_back({1'b0, 8'h3C});
        ext_frame("ext_3c", fbits(8'h3C, 1'b1, 1'b0), FL, nval, nab);
        chk("ext_3c_nvalid", 32'(nval), 32'd1);
        chk("ext_3c_nabort", 32'(nab), 32'd0);
        ext_frame("ext_short", fbits(8'hFF, 1'b1, 1'b0), 5, nval, nab);
        chk("short_nvalid", 32'(nval), 32'd0);
        chk("short_nabort", 32'(nab), 32'd1);
        chk("short_rx_data_held", 32'(rx_data), 32'h3C);
        exp_q.push_back({1'b0, 8'h5A});
        exp_q.push_back({1'b0, 8'hC3});
        ext_frame("ext_b2b", fbits(8'h5A, 1'b1, 1'b0) | (fbits(8'hC3, 1'b1, 1'b0) << FL),
                  2 * FL, nval, nab);
        chk("ext_b2b_nvalid", 32'(nval), 32'd2);
        chk("ext_b2b_nabort", 32'(nab), 32'd0);

        // Loopback switched mid-frame
        for (int i = 0; i < 3; i++) begin
            ser_in_ena = 1'b1; ser_in = 1'b1;
            step();
        end
        loopback = 1'b1;
        step();
        chk("lb_switch_abort", 32'({rx_abort, rx_valid}), 32'b10);
        ser_in_ena = 1'b0; ser_in = 1'b0;
        step();
        chk("lb_switch_data_held", 32'(rx_data), 32'hC3);

`ifdef PARITY_EN
        loopback = 1'b0;
        step();
        exp_q.push_back({1'b1, 8'h03});
        ext_frame("par_bad", fbits(8'h03, 1'b1, 1'b1), FL, nval, nab);
        chk("par_bad_nvalid", 32'(nval), 32'd1);
        loopback = 1'b1;
        step();
`endif

        // Reset in the middle of a TX frame
        n = 0;
        while (!tx_ready && n < 50) begin step(); n++; end
        tx_data = 8'hFF; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        step(); step(); step();
        chk("rst_mid_active", 32'(ser_ena), 32'd1);
        rst = 1'b1;
        step();
        chk("rst_mid_ser_ena", 32'(ser_ena), 32'd0);
        chk("rst_mid_ready_low", 32'(tx_ready), 32'd0);
        rst = 1'b0;
        step();
        chk("rst_mid_ready_back", 32'(tx_ready), 32'd1);
        nval = 0; nab = 0; n = 0;
        for (int c = 0; c < FL + 4; c++) begin
            if (rx_valid) nval++;
            if (rx_abort) nab++;
            if (ser_ena) n++;
            step();
        end
        chk("rst_mid_no_valid", 32'(nval), 32'd0);
        chk("rst_mid_no_abort", 32'(nab), 32'd0);
        chk("rst_mid_line_idle", 32'(n), 32'd0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk("sb_lsb_drained", 32'(exp_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
